// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the memory access unit: request size
// codes, FSM state encoding and the alignment rule.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  // A request is rejected when its size code is illegal or its byte offset
  // is not a multiple of the access size.
  function automatic logic is_bad_request(input logic [1:0] size,
                                          input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response channel plus the word-only memory port.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; the requester holds its fields stable while
// req_valid is high and req_ready is low. There is no response backpressure:
// resp_valid is a single-cycle pulse that the requester must sample in that
// cycle. Memory read data is combinational on mem_addr while mem_read is high;
// a write commits at the rising edge that ends a cycle with mem_write high.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_rdata;

  // CPU plus memory environment side.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_read, mem_write
  );

  // The access unit.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// Little-endian byte-lane steering: extracts and extends sub-word loads from
// a memory word, and merges sub-word store data into a memory word.
module byte_lane_unit
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [4:0]  sh;
  logic [31:0] shifted;

  assign sh      = {off, 3'b000};
  assign shifted = word >> sh;

  // Lane select and sign/zero extension for loads; lane replacement for stores.
  always_comb begin
    load_data  = word;
    store_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{sgn & shifted[7]}}, shifted[7:0]};
        store_data = (word & ~(32'h0000_00FF << sh)) |
                     ({24'd0, wdata[7:0]} << sh);
      end
      SZ_HALF: begin
        load_data  = {{16{sgn & shifted[15]}}, shifted[15:0]};
        store_data = (word & ~(32'h0000_FFFF << sh)) |
                     ({16'd0, wdata[15:0]} << sh);
      end
      default: begin
        load_data  = word;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Converts byte/half/word CPU loads and stores into a word-only memory
// protocol. Sub-word stores are done as read-modify-write; misaligned or
// illegal requests respond with an error and never touch memory.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic   clk,
  input  logic   reset,
  mem_access_unit_if.slave bus,
  output state_t state_dbg
);

  state_t            state;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              req_ready_q;
  logic              resp_valid_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic              accept;
  logic              accept_bad;
  logic [31:0]       lane_load;
  logic [31:0]       lane_store;

  assign accept     = bus.req_valid && req_ready_q;
  assign accept_bad = is_bad_request(bus.req_size, bus.req_addr[1:0]);

  // The lane unit always works on the word captured during RD; a word store
  // never depends on it because the merge passes wdata straight through.
  byte_lane_unit u_lanes (
    .word       (rdata_q),
    .off        (addr_q[1:0]),
    .size       (size_q),
    .sgn        (signed_q),
    .wdata      (wdata_q),
    .load_data  (lane_load),
    .store_data (lane_store)
  );

  // Request FSM: capture in IDLE, one RD and/or one WR cycle, then RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            write_q     <= bus.req_write;
            size_q      <= bus.req_size;
            signed_q    <= bus.req_signed;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            err_q       <= accept_bad;
            req_ready_q <= 1'b0;
            if (accept_bad) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
            end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
              state       <= WR;
              mem_write_q <= 1'b1;
            end else begin
              state      <= RD;
              mem_read_q <= 1'b1;
            end
          end
        end
        RD: begin
          rdata_q    <= bus.mem_rdata;
          mem_read_q <= 1'b0;
          if (write_q) begin
            state       <= WR;
            mem_write_q <= 1'b1;
          end else begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
          end
        end
        WR: begin
          mem_write_q  <= 1'b0;
          state        <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state        <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_valid_q & err_q;
  assign bus.resp_rdata = (resp_valid_q && !write_q && !err_q) ? lane_load : 32'd0;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata  = mem_write_q ? lane_store : 32'd0;
  assign state_dbg      = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: fixed vectors, hand sequences for back-to-back,
// reset and reset-priority corners, and random requests against a byte-array
// reference model.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg;
  int     checks;
  int     failures;

  mem_access_unit_if #(.ADDR_W(32)) bus();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory environment ----------------
  logic [31:0] mem_words [0:63];

  function automatic logic [31:0] init_pat(input int i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.mem_rdata = mem_words[bus.mem_addr[7:2]];

  // Memory shares the unit's reset; a write commits at the rising edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem_words[i] <= init_pat(i);
    end else if (bus.mem_write) begin
      mem_words[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_bytes [0:255];

  task automatic ref_init();
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = init_pat(i);
      for (int b = 0; b < 4; b++) ref_bytes[i*4+b] = w[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_bytes[{a[7:2], 2'b00} + b];
    return w;
  endfunction

  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er,
                       output int lat, output int nrd, output int nwr);
    int nb;
    int base;
    logic [31:0] v;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    base = int'(a[7:0]);
    er   = (nb == 0) || ((base % nb) != 0);
    rd   = 32'd0;
    if (er) begin
      lat = 1; nrd = 0; nwr = 0;
    end else if (w) begin
      for (int i = 0; i < nb; i++) ref_bytes[base+i] = wd[8*i +: 8];
      lat = (nb == 4) ? 2 : 3;
      nrd = (nb == 4) ? 0 : 1;
      nwr = 1;
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_bytes[base+i];
      if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rd = v; lat = 2; nrd = 1; nwr = 0;
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
  endtask

  task automatic set_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  // Called at a negedge while a request is in flight.
  task automatic sample_busy(input logic [31:0] a, inout int nrd, inout int nwr);
    if (bus.mem_read)  nrd++;
    if (bus.mem_write) nwr++;
    if (bus.mem_read || bus.mem_write) chk("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
    if (!bus.mem_write) chk("mem_wdata_idle", bus.mem_wdata, 32'd0);
    chk("busy_ready", 32'(bus.req_ready), 32'd0);
  endtask

  // Drive one request and measure the response; returns at the negedge
  // after the response cycle.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int nrd, output int nwr);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    set_req(w, sz, sg, a, wd);
    bus.req_valid = 1'b1;
    @(posedge clk);
    lat = 1; nrd = 0; nwr = 0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    sample_busy(a, nrd, nwr);
    while (!bus.resp_valid && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      sample_busy(a, nrd, nwr);
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    @(negedge clk);
    chk("resp_pulse_end", 32'(bus.resp_valid), 32'd0);
    chk("ready_after_resp", 32'(bus.req_ready), 32'd1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nrd;
    int          nwr;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic fill_vectors();
    vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h80, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 0, 1};
    vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1, 0};
    vecs[2]  = '{1'b1, SZ_WORD, 1'b0, 32'h80, 32'h12F4_5678, 32'h0,         1'b0, 2, 0, 1};
    vecs[3]  = '{1'b0, SZ_BYTE, 1'b1, 32'h82, 32'h0,         32'hFFFF_FFF4, 1'b0, 2, 1, 0};
    vecs[4]  = '{1'b0, SZ_BYTE, 1'b0, 32'h82, 32'h0,         32'h0000_00F4, 1'b0, 2, 1, 0};
    vecs[5]  = '{1'b0, SZ_HALF, 1'b1, 32'h82, 32'h0,         32'h0000_12F4, 1'b0, 2, 1, 0};
    vecs[6]  = '{1'b1, SZ_WORD, 1'b0, 32'h80, 32'h1122_3344, 32'h0,         1'b0, 2, 0, 1};
    vecs[7]  = '{1'b1, SZ_BYTE, 1'b0, 32'h81, 32'h5555_55AB, 32'h0,         1'b0, 3, 1, 1};
    vecs[8]  = '{1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0,         32'h1122_AB44, 1'b0, 2, 1, 0};
    vecs[9]  = '{1'b1, SZ_HALF, 1'b0, 32'h82, 32'hFFFF_CDEF, 32'h0,         1'b0, 3, 1, 1};
    vecs[10] = '{1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0,         32'hCDEF_AB44, 1'b0, 2, 1, 0};
    vecs[11] = '{1'b0, SZ_HALF, 1'b1, 32'h80, 32'h0,         32'hFFFF_AB44, 1'b0, 2, 1, 0};
    vecs[12] = '{1'b0, SZ_BYTE, 1'b1, 32'h83, 32'h0,         32'hFFFF_FFCD, 1'b0, 2, 1, 0};
    vecs[13] = '{1'b0, SZ_BYTE, 1'b0, 32'h81, 32'h0,         32'h0000_00AB, 1'b0, 2, 1, 0};
    vecs[14] = '{1'b0, SZ_HALF, 1'b1, 32'h83, 32'h0,         32'h0,         1'b1, 1, 0, 0};
    vecs[15] = '{1'b1, SZ_WORD, 1'b0, 32'h86, 32'h1234_5678, 32'h0,         1'b1, 1, 0, 0};
    vecs[16] = '{1'b0, SZ_ILL,  1'b0, 32'h80, 32'h0,         32'h0,         1'b1, 1, 0, 0};
    vecs[17] = '{1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0,         32'hCDEF_AB44, 1'b0, 2, 1, 0};
  endtask

  // ---------------- main sequence ----------------
  logic [32:0] exp_q [$];

  initial begin
    logic [31:0] rd, m_rd, r, lo;
    logic        er, m_er;
    int          lat, nrd, nwr, m_lat, m_nrd, m_nwr;
    logic        bw [3];
    logic [1:0]  bsz [3];
    logic [31:0] ba [3];
    logic [31:0] bwd [3];
    int          idx, accepts, resps, cyc;
    logic        busy, took;
    logic [32:0] e;

    checks = 0;
    failures = 0;
    idle_inputs();
    reset = 1'b1;
    ref_init();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,      32'd0);
    chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
    chk("rst_mem_read",   32'(bus.mem_read),   32'd0);
    chk("rst_mem_write",  32'(bus.mem_write),  32'd0);
    chk("rst_mem_wdata",  bus.mem_wdata,       32'd0);
    chk("rst_mem_addr",   bus.mem_addr,        32'd0);
    chk("rst_state",      32'(dbg),            32'(IDLE));

    // Directed vectors.
    fill_vectors();
    for (int i = 0; i < NVEC; i++) begin
      do_req(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, rd, er, lat, nrd, nwr);
      model(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, m_rd, m_er, m_lat, m_nrd, m_nwr);
      chk($sformatf("vec%0d_rdata", i),   rd,          vecs[i].rd);
      chk($sformatf("vec%0d_err", i),     32'(er),     32'(vecs[i].er));
      chk($sformatf("vec%0d_latency", i), 32'(lat),    32'(vecs[i].lat));
      chk($sformatf("vec%0d_reads", i),   32'(nrd),    32'(vecs[i].nrd));
      chk($sformatf("vec%0d_writes", i),  32'(nwr),    32'(vecs[i].nwr));
      chk($sformatf("vec%0d_mem", i),     mem_words[vecs[i].a[7:2]], ref_word(vecs[i].a));
    end

    // Back-to-back: req_valid held high across three requests.
    bw[0] = 1'b1; bsz[0] = SZ_WORD; ba[0] = 32'h20; bwd[0] = 32'hA5A5_1234;
    bw[1] = 1'b1; bsz[1] = SZ_BYTE; ba[1] = 32'h23; bwd[1] = 32'hFFFF_FF7E;
    bw[2] = 1'b0; bsz[2] = SZ_WORD; ba[2] = 32'h20; bwd[2] = 32'h0;
    @(negedge clk);
    idx = 0; accepts = 0; resps = 0; cyc = 0; busy = 1'b0;
    set_req(bw[0], bsz[0], 1'b0, ba[0], bwd[0]);
    bus.req_valid = 1'b1;
    while (resps < 3 && cyc < 60) begin
      chk("bb_ready", 32'(bus.req_ready), 32'(!busy));
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("bb_extra_resp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("bb_rdata", bus.resp_rdata, e[31:0]);
          chk("bb_err", 32'(bus.resp_err), 32'(e[32]));
        end
        resps++;
        busy = 1'b0;
      end
      took = 1'b0;
      if (bus.req_valid && bus.req_ready) begin
        model(bw[idx], bsz[idx], 1'b0, ba[idx], bwd[idx], m_rd, m_er, m_lat, m_nrd, m_nwr);
        exp_q.push_back({m_er, m_rd});
        accepts++;
        idx++;
        busy = 1'b1;
        took = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (took) begin
        if (idx < 3) set_req(bw[idx], bsz[idx], 1'b0, ba[idx], bwd[idx]);
        else bus.req_valid = 1'b0;
      end
    end
    chk("bb_accepts", 32'(accepts), 32'd3);
    chk("bb_resps", 32'(resps), 32'd3);
    chk("bb_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("bb_final_word", mem_words[8], 32'h7EA5_1234);
    repeat (3) begin
      @(negedge clk);
      chk("bb_no_extra", 32'(bus.resp_valid), 32'd0);
    end

    // Random requests against the reference model.
    for (int n = 0; n < 300; n++) begin
      logic       w, sg;
      logic [1:0] sz;
      logic [31:0] a, wd;
      r  = $urandom();
      lo = $urandom_range(0, 255);
      a  = {r[31:8], lo[7:0]};
      wd = $urandom();
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      do_req(w, sz, sg, a, wd, rd, er, lat, nrd, nwr);
      model(w, sz, sg, a, wd, m_rd, m_er, m_lat, m_nrd, m_nwr);
      chk("rnd_rdata",   rd,        m_rd);
      chk("rnd_err",     32'(er),   32'(m_er));
      chk("rnd_latency", 32'(lat),  32'(m_lat));
      chk("rnd_reads",   32'(nrd),  32'(m_nrd));
      chk("rnd_writes",  32'(nwr),  32'(m_nwr));
      chk("rnd_mem",     mem_words[a[7:2]], ref_word(a));
    end

    // Reset has priority over an acceptance in the same cycle.
    @(negedge clk);
    set_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
    bus.req_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    chk("rstprio_state", 32'(dbg), 32'(IDLE));
    chk("rstprio_ready", 32'(bus.req_ready), 32'd1);
    chk("rstprio_read",  32'(bus.mem_read), 32'd0);
    chk("rstprio_addr",  bus.mem_addr, 32'd0);
    ref_init();

    // Reset during the RD cycle of a byte store.
    @(negedge clk);
    set_req(1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h0000_00EE);
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstmid_in_rd", 32'(bus.mem_read), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_init();
    chk("rstmid_state", 32'(dbg), 32'(IDLE));
    chk("rstmid_ready", 32'(bus.req_ready), 32'd1);
    chk("rstmid_resp",  32'(bus.resp_valid), 32'd0);
    chk("rstmid_write", 32'(bus.mem_write), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("rstmid_no_write", 32'(bus.mem_write), 32'd0);
      chk("rstmid_no_resp",  32'(bus.resp_valid), 32'd0);
    end
    chk("rstmid_mem", mem_words[16], ref_word(32'h40));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly upstream of the unified instruction/data memory in the multi-cycle CPU. It converts CPU load/store requests (byte, halfword, word; signed or unsigned) into the word-only memory protocol.
- Memory read data is combinational, valid in the same cycle as mem_read/mem_addr. Memory writes commit at posedge clk.
- Sub-word stores use a read-modify-write sequence.
- Misaligned or illegal requests are rejected without touching memory.

Parameters:
- ADDR_W, 32, CPU byte-address width
- DATA_W, 32, word width; the unit is fixed at 32, other values are unsupported

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  sign-extend loads; ignored for stores and word loads
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned or illegal size
- mem_addr  out  32  word address to memory, {addr_q[31:2],2'b00}
- mem_wdata  out  32  merged write word; 0 outside WR
- mem_read  out  1  high only in RD
- mem_write  out  1  high only in WR
- mem_rdata  in  32  combinational memory read data

Behaviour:
- Byte lanes are little-endian: lane n = bits [8n+7:8n]. Byte offset off = addr_q[1:0]. The halfword at off=2 occupies bits [31:16].
- States: IDLE, RD, WR, RESP.
- Request capture:
  - On req_valid && req_ready, register write, size, signed, addr, wdata.
  - Error condition: size==11, or half with addr[0]=1, or word with addr[1:0]≠0.
- Transitions from IDLE:
  - error → RESP with err_q=1
  - load → RD
  - word store → WR
  - byte/half store → RD
- RD:
  - mem_read=1; capture mem_rdata into rdata_q at the clock edge.
  - Load → RESP. Sub-word store → WR.
- WR:
  - mem_write=1.
  - mem_wdata = req_wdata for a word store; otherwise rdata_q with the addressed lane(s) replaced by req_wdata[7:0] or [15:0].
  - → RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_rdata/resp_err driven from registers; → IDLE.
  - No backpressure: the CPU must sample the response in that cycle.
- Load extension:
  - byte: lane selected by off, bits[31:8] = req_signed ? bit7 : 0
  - half: bits[31:16] = req_signed ? bit15 : 0
  - word: unmodified
- Latency, counted from the accept edge to resp_valid high:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- req_ready=0 in RD/WR/RESP. req_valid during those states is ignored and not queued. A new request may be accepted in the cycle after RESP.
- Errors never assert mem_read or mem_write.
- Reset, synchronous:
  - state=IDLE; all captured registers=0.
  - Outputs after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_wdata=0, mem_addr=0.
  - Reset asserted in WR: mem_write drops at the next edge. The memory is reset by the same signal, so no partial store survives.
  - Reset has priority over an acceptance in the same cycle.
- Address bits above the memory's index range pass through unchanged. Wrap-around is the memory's concern.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state encoding IDLE/RD/WR/RESP
  - an alignment-check function
- One combinational sub-module, byte_lane_unit, performs load extract/extend and store merge from (word, off, size, signed, wdata).
- The FSM and registers stay in mem_access_unit.

Test Plan:
- Word store then load: store addr 0x80, data 0xDEADBEEF, then word load 0x80. Required: the store gives resp_valid exactly 2 cycles after acceptance; the load returns 0xDEADBEEF with resp_err=0.
- Signed/unsigned byte loads: memory word 0x80 = 0x12F4_5678. Byte load at 0x82: signed → 0xFFFFFFF4; unsigned → 0x000000F4. Halfword load at 0x82 signed → 0x000012F4.
- Sub-word store RMW: word 0x80 = 0x11223344. Byte store 0xAB at 0x81 → memory 0x1122AB44. Then half store 0xCDEF at 0x82 → memory 0xCDEFAB44. Each: mem_read for one cycle then mem_write for one cycle; resp_valid 3 cycles after acceptance.
- Misaligned/illegal requests: half load at 0x83, word store at 0x86, size=11 at 0x80. Each: resp_valid 1 cycle after acceptance with resp_err=1, resp_rdata=0; mem_read and mem_write never asserted; memory unchanged.
- Back-to-back requests: req_valid held high with three requests. req_ready is low during RD/WR/RESP, each request is accepted only from IDLE, and no request is lost or duplicated.
- Reset mid-operation: assert reset during the RD cycle of a byte store. Next cycle: state IDLE, req_ready=1, resp_valid=0; no mem_write pulse occurs.
